program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
// - Responder to the boot-phase requests of the CPU state controller:
//   send 0x99, take the program size, stream the program into instruction
//   memory, then send 0xAA.
// - Sits between the state controller and the UART byte TX/RX cores.
// - Reports completion of each phase on a *_finished output.
// PARAMETERS
// - IMEM_ADDR_WIDTH  15  word-address width of instruction memory; depth = 2**IMEM_ADDR_WIDTH words
// PORTS
// - clk                                 in   1   system clock; single clock domain
// - reset                               in   1   asynchronous, active-high reset
// - transmit_0x99                       in   1   level request: send byte 0x99
// - receive_program_data_size           in   1   level request: receive 4-byte size
// - receive_program_data                in   1   level request: receive program words
// - transmit_0xAA                       in   1   level request: send byte 0xAA
// - transmit_0x99_finished              out  1   phase done (level, see BEHAVIOUR)
// - receive_program_data_size_finished  out  1   phase done
// - receive_program_data_finished       out  1   phase done
// - transmit_0xAA_finished              out  1   phase done
// - rx_data                             in   8   byte from UART RX
// - rx_valid                            in   1   1-cycle strobe; rx_data valid this cycle
// - tx_data                             out  8   byte to UART TX
// - tx_start                            out  1   1-cycle strobe; UART TX latches tx_data
// - tx_busy                             in   1   UART TX busy; high from the cycle after tx_start until the stop bit ends
// - imem_we                             out  1   instruction-memory write strobe
// - imem_addr                           out  IMEM_ADDR_WIDTH  word address
// - imem_wdata                          out  32  instruction word
// - load_error                          out  1   sticky: size exceeded depth; cleared only by reset
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; counters and size register cleared.
// - States and transitions:
//   - IDLE -> TX_SEND on transmit_0x99 or transmit_0xAA.
//   - IDLE -> SIZE_RX on receive_program_data_size.
//   - IDLE -> DATA_RX on receive_program_data.
//   - If several requests are high, priority is 0x99 > size > data > 0xAA.
// - TX_SEND:
//   - Wait for tx_busy==0.
//   - Then pulse tx_start for 1 cycle, with tx_data = 8'h99 or 8'hAA.
//   - -> TX_WAIT.
// - TX_WAIT:
//   - Ignore tx_busy in the first cycle after tx_start.
//   - Then wait for tx_busy==0 -> DONE.
// - SIZE_RX:
//   - Collect 4 bytes on rx_valid, little-endian (first byte = bits 7:0).
//   - Size counts 32-bit words.
//   - After the 4th byte -> DONE.
// - DATA_RX:
//   - Assemble each word from 4 bytes, little-endian.
//   - On the 4th byte, next cycle: imem_we=1 for exactly 1 cycle,
//     imem_addr = word index (starts at 0), imem_wdata = assembled word.
//   - The word index increments after each write.
//   - Write latency: 1 cycle after the rx_valid of the 4th byte.
//   - When index == size -> DONE.
//   - Size 0: go straight to DONE the cycle after entry; no writes.
// - Overflow: words with index >= 2**IMEM_ADDR_WIDTH are consumed but not
//   written (imem_we stays 0), load_error is set, and the phase still completes.
// - Address never wraps.
// - DONE:
//   - Hold the matching *_finished=1 while its request stays high.
//   - Request low -> finished=0 next cycle, state -> IDLE.
//   - This makes finished robust to controller stall.
// - Request deasserted mid-phase (before DONE):
//   - Abort to IDLE; partial byte/word is discarded.
//   - A tx_start already issued is not retracted.
// - rx_valid outside SIZE_RX/DATA_RX is ignored; bytes are dropped.
// - rx_valid while in TX states is ignored.
// - The byte counter is 2 bits and wraps 3 -> 0 at each word.
// - The word counter is 32 bits and is compared against the size register.
// - Async reset mid-phase: immediate return to reset values.
//   The loaded size and imem contents already written are not retained by this block.
// STRUCTURE
// - Shared package:
//   - loader_state_t enum (IDLE, TX_SEND, TX_WAIT, SIZE_RX, DATA_RX, DONE).
//   - Constants BOOT_REQ_BYTE=8'h99 and BOOT_ACK_BYTE=8'hAA.
//   - BYTES_PER_WORD=4.
// - One sub-module: byte_word_assembler.
//   - 8-bit in, 32-bit out, little-endian, with word_valid strobe and clear.
//   - Used by both SIZE_RX and DATA_RX.
// TESTING
// - Send 0x99:
//   - Stimulus: transmit_0x99=1, with a TX model holding tx_busy for 10 cycles.
//   - Expect one tx_start with tx_data=8'h99, then transmit_0x99_finished=1
//     until the request drops, and no second tx_start.
// - Size reception:
//   - Stimulus: receive_program_data_size with bytes 03 00 00 00.
//   - Expect size=3 and finished after the 4th rx_valid.
// - Data reception:
//   - Stimulus: receive_program_data after size=3, with bytes 13 00 00 00 | 93 00 10 00 | 6F 00 00 00.
//   - Expect imem writes at addr 0/1/2 of 0x00000013, 0x00100093 and 0x0000006F,
//     each 1 cycle after the 4th byte, then finished.
// - Size 0:
//   - Stimulus: size=0, then receive_program_data.
//   - Expect finished with no imem_we.
// - Overflow:
//   - Stimulus: IMEM_ADDR_WIDTH=2 and size=6.
//   - Expect 4 writes (addr 0..3), the last 2 words dropped, load_error=1, finished=1.
// - Abort and reset:
//   - Stimulus: drop receive_program_data after 2 bytes, then restart.
//   - Expect the first write to be at addr 0 with fresh bytes.
//   - Stimulus: assert reset mid-TX_WAIT.
//   - Expect all outputs 0 immediately.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-phase program loader.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX_SEND,
        TX_WAIT,
        SIZE_RX,
        DATA_RX,
        DONE
    } loader_state_t;

    // Which controller request owns the current phase.
    typedef enum logic [1:0] {
        PH_TX_99,
        PH_SIZE,
        PH_DATA,
        PH_TX_AA
    } loader_phase_t;

    localparam logic [7:0] BOOT_REQ_BYTE  = 8'h99;
    localparam logic [7:0] BOOT_ACK_BYTE  = 8'hAA;
    localparam int         BYTES_PER_WORD = 4;

    function automatic logic [7:0] tx_byte_for(input loader_phase_t phase);
        return (phase == PH_TX_AA) ? BOOT_ACK_BYTE : BOOT_REQ_BYTE;
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses
// the cycle after the fourth byte, with word_data holding the assembled word.
module byte_word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic [31:0] word_data,
    output logic        word_valid
);

    logic [1:0] byte_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_data  <= '0;
            byte_cnt   <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            word_data  <= '0;
            byte_cnt   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));
            if (byte_valid) begin
                // shifting in from the top leaves the first byte in bits 7:0
                word_data <= {byte_data, word_data[31:8]};
                byte_cnt  <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot-phase responder: sends 0x99/0xAA over UART TX, receives the program
// size and streams the program words from UART RX into instruction memory.
//
// state   | meaning
// IDLE    | waiting for a controller request
// TX_SEND | waiting for UART TX idle, then pulsing tx_start
// TX_WAIT | byte in flight; done once tx_busy falls
// SIZE_RX | collecting the 4-byte word count
// DATA_RX | collecting program words and writing them to imem
// DONE    | holding *_finished until the request drops
module program_loader
    import program_loader_pkg::*;
#(
    parameter int IMEM_ADDR_WIDTH = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       transmit_0x99,
    input  logic                       receive_program_data_size,
    input  logic                       receive_program_data,
    input  logic                       transmit_0xAA,
    output logic                       transmit_0x99_finished,
    output logic                       receive_program_data_size_finished,
    output logic                       receive_program_data_finished,
    output logic                       transmit_0xAA_finished,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic                       imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]                imem_wdata,
    output logic                       load_error
);

    loader_state_t state, state_next;
    loader_phase_t phase, phase_next;

    logic        tx_first;
    logic [31:0] size_reg;
    logic [31:0] word_cnt;
    logic        req_active;
    logic        receiving;
    logic        word_in_range;
    logic        word_accept;
    logic [31:0] asm_word;
    logic        asm_valid;

    always_comb begin
        req_active = 1'b0;
        case (phase)
            PH_TX_99: req_active = transmit_0x99;
            PH_SIZE:  req_active = receive_program_data_size;
            PH_DATA:  req_active = receive_program_data;
            PH_TX_AA: req_active = transmit_0xAA;
            default:  req_active = 1'b0;
        endcase
    end

    assign receiving     = (state == SIZE_RX) || (state == DATA_RX);
    assign word_in_range = (word_cnt >> IMEM_ADDR_WIDTH) == 32'd0;

    byte_word_assembler u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (!receiving),
        .byte_data  (rx_data),
        .byte_valid (rx_valid && receiving),
        .word_data  (asm_word),
        .word_valid (asm_valid)
    );

    always_comb begin
        state_next = state;
        phase_next = phase;
        tx_start   = 1'b0;
        tx_data    = '0;
        case (state)
            IDLE: begin
                if (transmit_0x99) begin
                    state_next = TX_SEND;
                    phase_next = PH_TX_99;
                end else if (receive_program_data_size) begin
                    state_next = SIZE_RX;
                    phase_next = PH_SIZE;
                end else if (receive_program_data) begin
                    state_next = DATA_RX;
                    phase_next = PH_DATA;
                end else if (transmit_0xAA) begin
                    state_next = TX_SEND;
                    phase_next = PH_TX_AA;
                end
            end
            TX_SEND: begin
                if (!req_active) begin
                    state_next = IDLE;
                end else if (!tx_busy) begin
                    tx_start   = 1'b1;
                    tx_data    = tx_byte_for(phase);
                    state_next = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // tx_busy only becomes meaningful one cycle after tx_start
                if (!req_active) begin
                    state_next = IDLE;
                end else if (!tx_first && !tx_busy) begin
                    state_next = DONE;
                end
            end
            SIZE_RX: begin
                if (!req_active) begin
                    state_next = IDLE;
                end else if (asm_valid) begin
                    state_next = DONE;
                end
            end
            DATA_RX: begin
                if (!req_active) begin
                    state_next = IDLE;
                end else if (word_cnt == size_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!req_active) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Words beyond the memory depth are counted but never written.
    assign word_accept = (state == DATA_RX) && req_active && asm_valid && (word_cnt != size_reg);
    assign imem_we     = word_accept && word_in_range;
    assign imem_addr   = word_cnt[IMEM_ADDR_WIDTH-1:0];
    assign imem_wdata  = imem_we ? asm_word : '0;

    assign transmit_0x99_finished             = (state == DONE) && (phase == PH_TX_99);
    assign receive_program_data_size_finished = (state == DONE) && (phase == PH_SIZE);
    assign receive_program_data_finished      = (state == DONE) && (phase == PH_DATA);
    assign transmit_0xAA_finished             = (state == DONE) && (phase == PH_TX_AA);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= PH_TX_99;
            tx_first   <= 1'b0;
            size_reg   <= '0;
            word_cnt   <= '0;
            load_error <= 1'b0;
        end else begin
            state    <= state_next;
            phase    <= phase_next;
            tx_first <= (state == TX_SEND) && (state_next == TX_WAIT);
            if ((state == SIZE_RX) && (state_next == DONE)) begin
                size_reg <= asm_word;
            end
            if (state != DATA_RX) begin
                word_cnt <= '0;
            end else if (word_accept) begin
                word_cnt <= word_cnt + 32'd1;
            end
            if (word_accept && !word_in_range) begin
                load_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a 10-cycle UART TX busy model
// and an instruction-memory write monitor.
module tb_program_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          transmit_0x99;
    logic          receive_program_data_size;
    logic          receive_program_data;
    logic          transmit_0xAA;
    logic          transmit_0x99_finished;
    logic          receive_program_data_size_finished;
    logic          receive_program_data_finished;
    logic          transmit_0xAA_finished;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          load_error;

    program_loader #(.IMEM_ADDR_WIDTH(AW)) dut (
        .clk                                (clk),
        .reset                              (reset),
        .transmit_0x99                      (transmit_0x99),
        .receive_program_data_size          (receive_program_data_size),
        .receive_program_data               (receive_program_data),
        .transmit_0xAA                      (transmit_0xAA),
        .transmit_0x99_finished             (transmit_0x99_finished),
        .receive_program_data_size_finished (receive_program_data_size_finished),
        .receive_program_data_finished      (receive_program_data_finished),
        .transmit_0xAA_finished             (transmit_0xAA_finished),
        .rx_data                            (rx_data),
        .rx_valid                           (rx_valid),
        .tx_data                            (tx_data),
        .tx_start                           (tx_start),
        .tx_busy                            (tx_busy),
        .imem_we                            (imem_we),
        .imem_addr                          (imem_addr),
        .imem_wdata                         (imem_wdata),
        .load_error                         (load_error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    int          tx_count = 0;
    logic [7:0]  tx_last = '0;
    int          last_rx_cyc = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_lat_q[$];

    localparam logic [31:0] PROG0 = 32'h0000_0013;
    localparam logic [31:0] PROG1 = 32'h0010_0093;
    localparam logic [31:0] PROG2 = 32'h0000_006F;

    assign tx_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_start) begin
            busy_cnt <= 10;
            tx_count <= tx_count + 1;
            tx_last  <= tx_data;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (rx_valid) last_rx_cyc <= cyc;
        if (imem_we) begin
            wr_addr_q.push_back(32'(imem_addr));
            wr_data_q.push_back(imem_wdata);
            wr_lat_q.push_back(cyc - last_rx_cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic fin(input int which);
        case (which)
            0:       return transmit_0x99_finished;
            1:       return receive_program_data_size_finished;
            2:       return receive_program_data_finished;
            default: return transmit_0xAA_finished;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_fin(input int which, input string tag, input int budget);
        int k = 0;
        while (!fin(which) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(fin(which)), 32'd1);
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_lat_q.delete();
    endtask

    task automatic load_size(input logic [31:0] size);
        receive_program_data_size = 1'b1;
        send_word(size);
        wait_fin(1, "size_fin", 10);
        receive_program_data_size = 1'b0;
        tick(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        transmit_0x99 = 1'b0;
        receive_program_data_size = 1'b0;
        receive_program_data = 1'b0;
        transmit_0xAA = 1'b0;
        rx_data = '0;
        rx_valid = 1'b0;
        tick(3);
        check("rst_flags", 32'({tx_start, imem_we, load_error, transmit_0x99_finished,
                                receive_program_data_size_finished, receive_program_data_finished,
                                transmit_0xAA_finished}), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_imem", imem_wdata | 32'(imem_addr), 32'd0);
        reset = 1'b0;
        tick(2);

        // send 0x99
        transmit_0x99 = 1'b1;
        wait_fin(0, "fin_99", 60);
        check("tx99_count", 32'(tx_count), 32'd1);
        check("tx99_byte", 32'(tx_last), 32'h99);
        check("tx99_busy_clear", 32'(tx_busy), 32'd0);
        tick(5);
        check("fin_99_hold", 32'(fin(0)), 32'd1);
        check("tx99_no_repeat", 32'(tx_count), 32'd1);
        transmit_0x99 = 1'b0;
        tick(1);
        check("fin_99_drop", 32'(fin(0)), 32'd0);
        tick(1);

        // size = 3, finished only after the 4th byte
        receive_program_data_size = 1'b1;
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h00);
        tick(2);
        check("size_not_early", 32'(fin(1)), 32'd0);
        send_byte(8'h00);
        wait_fin(1, "fin_size3", 10);
        receive_program_data_size = 1'b0;
        tick(2);

        // three program words
        clear_writes();
        receive_program_data = 1'b1;
        send_word(PROG0);
        send_word(PROG1);
        send_word(PROG2);
        wait_fin(2, "fin_data", 10);
        check("data_wr_count", 32'(wr_addr_q.size()), 32'd3);
        if (wr_addr_q.size() == 3) begin
            check("data_addr0", wr_addr_q[0], 32'd0);
            check("data_addr1", wr_addr_q[1], 32'd1);
            check("data_addr2", wr_addr_q[2], 32'd2);
            check("data_word0", wr_data_q[0], PROG0);
            check("data_word1", wr_data_q[1], PROG1);
            check("data_word2", wr_data_q[2], PROG2);
            for (int i = 0; i < 3; i++) check("data_latency", 32'(wr_lat_q[i]), 32'd1);
        end
        check("data_no_error", 32'(load_error), 32'd0);
        receive_program_data = 1'b0;
        tick(1);
        check("fin_data_drop", 32'(fin(2)), 32'd0);
        tick(1);

        // size beats 0xAA when both are requested
        receive_program_data_size = 1'b1;
        transmit_0xAA = 1'b1;
        tick(3);
        check("prio_no_tx", 32'(tx_count), 32'd1);
        send_word(32'd0);
        wait_fin(1, "fin_size0", 10);
        check("prio_aa_pending", 32'(fin(3)), 32'd0);
        receive_program_data_size = 1'b0;
        wait_fin(3, "fin_aa", 60);
        check("txaa_count", 32'(tx_count), 32'd2);
        check("txaa_byte", 32'(tx_last), 32'hAA);
        transmit_0xAA = 1'b0;
        tick(2);

        // size 0: done the cycle after entry, nothing written
        clear_writes();
        receive_program_data = 1'b1;
        tick(2);
        check("size0_fin", 32'(fin(2)), 32'd1);
        tick(3);
        check("size0_no_write", 32'(wr_addr_q.size()), 32'd0);
        receive_program_data = 1'b0;
        tick(2);

        // abort after two bytes, restart with fresh bytes
        load_size(32'd3);
        clear_writes();
        receive_program_data = 1'b1;
        send_byte(8'hAA);
        send_byte(8'hBB);
        receive_program_data = 1'b0;
        tick(2);
        check("abort_no_write", 32'(wr_addr_q.size()), 32'd0);
        receive_program_data = 1'b1;
        send_word(32'h4433_2211);
        send_word(32'h0102_0304);
        send_word(32'h0A0B_0C0D);
        wait_fin(2, "fin_restart", 10);
        check("restart_wr_count", 32'(wr_addr_q.size()), 32'd3);
        if (wr_addr_q.size() != 0) begin
            check("restart_addr0", wr_addr_q[0], 32'd0);
            check("restart_word0", wr_data_q[0], 32'h4433_2211);
        end
        receive_program_data = 1'b0;
        tick(2);

        // overflow: depth 4, size 6
        load_size(32'd6);
        clear_writes();
        receive_program_data = 1'b1;
        for (int k = 0; k < 6; k++) send_word(32'hC35A_A000 + 32'(k));
        wait_fin(2, "fin_ovf", 10);
        check("ovf_wr_count", 32'(wr_addr_q.size()), 32'd4);
        if (wr_addr_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("ovf_addr", wr_addr_q[k], 32'(k));
                check("ovf_word", wr_data_q[k], 32'hC35A_A000 + 32'(k));
            end
        end
        check("ovf_load_error", 32'(load_error), 32'd1);
        receive_program_data = 1'b0;
        tick(2);
        check("ovf_error_sticky", 32'(load_error), 32'd1);

        // async reset while waiting for the TX byte to finish
        transmit_0x99 = 1'b1;
        begin
            int k = 0;
            while (tx_count < 3 && k < 30) begin
                @(negedge clk);
                k++;
            end
        end
        check("rst_tx_started", 32'(tx_count), 32'd3);
        tick(2);
        reset = 1'b1;
        #1;
        check("midrst_flags", 32'({tx_start, imem_we, load_error, transmit_0x99_finished,
                                   receive_program_data_size_finished, receive_program_data_finished,
                                   transmit_0xAA_finished}), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        transmit_0x99 = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(3);
        check("post_rst_no_tx", 32'(tx_count), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
